// File: rtl/bcd_timer_counter.sv
// bcd_timer_counter: cascaded BCD down-counter (mm:ss when TIME_MODE=1) with clamped load and terminal-count pulse.
// Optional "+30 s" quick-start adder is built only when COUNTER_ADD30_EN is defined.
module bcd_timer_counter #(
  parameter int DIGITS = 4,
  parameter bit TIME_MODE = 1
) (
  input  logic                clk,
  input  logic                clr,
  input  logic [4*DIGITS-1:0] data,
  input  logic                loadn,
  input  logic                en,
  input  logic                add30,
  output logic [4*DIGITS-1:0] count,
  output logic [3:0]          ones,
  output logic                zero,
  output logic                tc
);
  function automatic logic [3:0] max_of(int i);
    return (TIME_MODE && i == 1) ? 4'd5 : 4'd9;
  endfunction
  logic [4*DIGITS-1:0] clamped, dec;
  always_comb begin
    logic b;
    b = 1'b1;
    clamped = '0;
    dec = '0;
    for (int i = 0; i < DIGITS; i++) begin
      clamped[4*i+:4] = data[4*i+:4] > max_of(i) ? max_of(i) : data[4*i+:4];
      dec[4*i+:4] = !b ? count[4*i+:4] : count[4*i+:4] == 4'd0 ? max_of(i) : count[4*i+:4] - 4'd1;
      b = b && count[4*i+:4] == 4'd0;
    end
  end
`ifdef COUNTER_ADD30_EN
  logic [4*DIGITS-1:0] inc;
  // +3 on the tens-of-seconds digit, carry ripples up; carry out of the top saturates
  always_comb begin
    logic c;
    logic [4:0] s;
    c = 1'b0;
    s = 5'd0;
    inc = '0;
    for (int i = 0; i < DIGITS; i++) begin
      s = {1'b0, count[4*i+:4]} + (i == 1 ? 5'd3 : 5'd0) + {4'd0, c};
      c = s > {1'b0, max_of(i)};
      inc[4*i+:4] = c ? s[3:0] - max_of(i) - 4'd1 : s[3:0];
    end
    if (c)
      for (int i = 0; i < DIGITS; i++) inc[4*i+:4] = max_of(i);
  end
`else
  logic unused_add30;
  assign unused_add30 = add30;
`endif
  always_ff @(posedge clk) begin
    tc <= 1'b0;
    if (clr) count <= '0;
    else if (!loadn) count <= clamped;
`ifdef COUNTER_ADD30_EN
    else if (add30) count <= inc;
`endif
    else if (en && !zero) begin
      count <= dec;
      tc <= dec == '0;
    end
  end
  assign ones = count[3:0];
  assign zero = count == '0;
endmodule
